alu_multicycle: RTL and testbench

Multi-cycle integer ALU that consumes the 4-bit `Operation` code produced by the ALU controller together with two operands, and returns a registered result over a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle; shifts run iteratively, one bit per cycle, to avoid a barrel shifter. It sits in the execute stage between operand muxing and the writeback/branch logic.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_comb.sv | 34 +++
 rtl/alu_multicycle.sv | 103 ++++++++++
 tb/tb_alu_multicycle.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and FSM states, used by the ALU controller and
// the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_EQ    = 4'b1000,
    ALU_NE    = 4'b1001,
    ALU_LT    = 4'b1010,
    ALU_GE    = 4'b1011,
    ALU_LTU   = 4'b1100,
    ALU_GEU   = 4'b1101,
    ALU_PASSB = 4'b1110,
    ALU_RSVD  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic, add/sub, compares and pass-through.
// Shift codes and the reserved code produce 0 here; shifts live in the top.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  // Compare ops return the condition zero-extended to the full width.
  always_comb begin
    result = '0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_XOR:   result = a ^ b;
      ALU_SUB:   result = a - b;
      ALU_EQ:    result = DATA_WIDTH'(a == b);
      ALU_NE:    result = DATA_WIDTH'(a != b);
      ALU_LT:    result = DATA_WIDTH'($signed(a) < $signed(b));
      ALU_GE:    result = DATA_WIDTH'($signed(a) >= $signed(b));
      ALU_LTU:   result = DATA_WIDTH'(a < b);
      ALU_GEU:   result = DATA_WIDTH'(a >= b);
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops via alu_comb, shifts iterate one bit per
// cycle; the result is returned over a valid/ready handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult
);

  alu_state_e            state_q, state_d;
  alu_op_e               op_q, op_d, op_in;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic [DATA_WIDTH-1:0] comb_result, shifted;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d, shamt;
  logic                  accept;

  assign op_in     = alu_op_e'(Operation);
  assign shamt     = SrcB[SHAMT_W-1:0];
  assign in_ready  = (state_q == ST_IDLE) && reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .op     (op_in),
    .a      (SrcA),
    .b      (SrcB),
    .result (comb_result)
  );

  // SRA keeps the accumulator MSB, which is always the original sign bit.
  always_comb begin
    case (op_q)
      ALU_SLL: shifted = {acc_q[DATA_WIDTH-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, acc_q[DATA_WIDTH-1:1]};
      default: shifted = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(op_in) && (shamt != '0)) begin
            state_d = ST_SHIFT;
            op_d    = op_in;
            acc_d   = SrcA;
            cnt_d   = shamt;
          end else begin
            state_d  = ST_DONE;
            result_d = is_shift_op(op_in) ? SrcA : comb_result;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shifted;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset aborts any operation in flight without exposing a partial result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_AND;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed literal vectors plus a
// randomized run checked every cycle against a behavioural model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference function straight from the op table, using native operators.
  function automatic logic [W-1:0] refAlu(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int sh;
    logic [W-1:0] r;
    sh = int'(b[4:0]);
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a ^ b;
      4'h4: r = a << sh;
      4'h5: r = a >> sh;
      4'h6: r = a - b;
      4'h7: r = $signed(a) >>> sh;
      4'h8: r = {31'b0, a == b};
      4'h9: r = {31'b0, a != b};
      4'hA: r = {31'b0, $signed(a) < $signed(b)};
      4'hB: r = {31'b0, $signed(a) >= $signed(b)};
      4'hC: r = {31'b0, a < b};
      4'hD: r = {31'b0, a >= b};
      4'hE: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an op is busy from accept until its result is taken;
  // a shift by n becomes visible n cycles later than a single-cycle op.
  bit           mInit  = 0;
  bit           mBusy  = 0;
  bit           mValid = 0;
  bit           mKnown = 0;
  int           mWait  = 0;
  logic [W-1:0] mResult = '0;

  always @(posedge clk) begin
    mInit = 1;
    if (!reset) begin
      mBusy = 0; mValid = 0; mKnown = 1; mWait = 0; mResult = '0;
    end else if (!mBusy) begin
      if (in_valid) begin
        mBusy   = 1;
        mResult = refAlu(Operation, SrcA, SrcB);
        mWait   = (Operation inside {4'h4, 4'h5, 4'h7}) ? int'(SrcB[4:0]) : 0;
        mValid  = (mWait == 0);
        mKnown  = mValid;
      end
    end else if (!mValid) begin
      mWait--;
      if (mWait == 0) begin
        mValid = 1; mKnown = 1;
      end
    end else if (out_ready) begin
      mBusy = 0; mValid = 0; mKnown = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (mInit) begin
      checkOutput("cmp_out_valid", W'(out_valid), W'(mValid));
      checkOutput("cmp_in_ready", W'(in_ready), W'(!mBusy && reset));
      if (mKnown) checkOutput("cmp_result", ALUResult, mResult);
    end
  end

  // One op with out_ready high; returns result and cycles from accept to valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, output logic [W-1:0] res,
                               output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) checkOutput("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = ALUResult;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int lat;
    string name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] res;
    int lat;
    bit sawValid;

    vecs[0]  = '{ALU_ADD,   32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1,  "add_wrap"};
    vecs[1]  = '{ALU_SUB,   32'h0,         32'h1,         32'hFFFF_FFFF, 1,  "sub_wrap"};
    vecs[2]  = '{ALU_SRA,   32'h8000_0000, 32'h4,         32'hF800_0000, 5,  "sra4"};
    vecs[3]  = '{ALU_SRL,   32'h8000_0000, 32'h0,         32'h8000_0000, 1,  "srl0"};
    vecs[4]  = '{ALU_SLL,   32'h1,         32'd31,        32'h8000_0000, 32, "sll31"};
    vecs[5]  = '{ALU_LT,    32'hFFFF_FFFF, 32'h1,         32'h1,         1,  "lt"};
    vecs[6]  = '{ALU_LTU,   32'hFFFF_FFFF, 32'h1,         32'h0,         1,  "ltu"};
    vecs[7]  = '{ALU_GEU,   32'hFFFF_FFFF, 32'h1,         32'h1,         1,  "geu"};
    vecs[8]  = '{ALU_EQ,    32'd5,         32'd5,         32'h1,         1,  "eq"};
    vecs[9]  = '{ALU_NE,    32'd5,         32'd5,         32'h0,         1,  "ne"};
    vecs[10] = '{ALU_PASSB, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1,  "passb"};
    vecs[11] = '{ALU_RSVD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1,  "rsvd"};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", W'(in_ready), 32'd0);
    checkOutput("rst_out_valid", W'(out_valid), 32'd0);
    checkOutput("rst_result", ALUResult, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rel_in_ready", W'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      checkOutput({vecs[i].name, "_res"}, res, vecs[i].res);
      checkOutput({vecs[i].name, "_lat"}, W'(lat), W'(vecs[i].lat));
      checkOutput({vecs[i].name, "_model"}, refAlu(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].res);
    end

    // Backpressure: result held, new requests ignored while DONE.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; Operation = ALU_ADD; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      Operation = ALU_SUB; SrcA = $urandom; SrcB = $urandom;
      checkOutput("bp_out_valid", W'(out_valid), 32'd1);
      checkOutput("bp_result", ALUResult, 32'd7);
      checkOutput("bp_in_ready", W'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_in_ready", W'(in_ready), 32'd1);
    checkOutput("bp_release_out_valid", W'(out_valid), 32'd0);

    // Reset dropped in the third cycle of a 10-bit shift.
    in_valid = 1'b1; Operation = ALU_SLL; SrcA = 32'h3; SrcB = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", W'(out_valid), 32'd0);
    checkOutput("abort_result", ALUResult, 32'd0);
    checkOutput("abort_in_ready", W'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_rel_in_ready", W'(in_ready), 32'd1);
    sawValid = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) sawValid = 1;
    end
    checkOutput("abort_no_valid", W'(sawValid), 32'd0);
    applyStimulus(ALU_ADD, 32'd1, 32'd2, res, lat);
    checkOutput("post_abort_res", res, 32'd3);
    checkOutput("post_abort_lat", W'(lat), 32'd1);

    // Randomized traffic with backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      Operation = 4'($urandom_range(0, 15));
      SrcA      = $urandom;
      SrcB      = $urandom;
      if ($urandom_range(0, 1) == 1) SrcB[4:0] = 5'($urandom_range(0, 3));
    end

    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
